// File: rtl/uc_arbiter.sv
// Unit-clause arbiter: pops implied literals from every PE round-robin, filters them
// against the variable assignment table and broadcasts new literals to all PEs.
module uc_arbiter #(
  parameter int NUM_PE   = 4,
  parameter int LIT_W    = 16,
  parameter int NUM_VARS = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic [NUM_PE-1:0]       UCQ_in_empty,
  input  logic [NUM_PE*LIT_W-1:0] UCQ_in2uarb_uc,
  output logic [NUM_PE-1:0]       ucarb2UCQ_in_pop,
  input  logic [NUM_PE-1:0]       UCQ_out_full,
  output logic [NUM_PE-1:0]       ucarb2UCQ_out_push,
  output logic [LIT_W-1:0]        ucarb2UCQ_out_uc,
  input  logic [NUM_PE-1:0]       proc_stall,
  output logic                    conflict,
  output logic                    lit_err,
  output logic                    quiescent
);

  localparam int PTR_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int IDX_W = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_BCAST, S_HALT} state_t;

  state_t              state, state_next;
  logic [PTR_W-1:0]    rr_ptr;
  logic [LIT_W-1:0]    lit_reg;
  logic [NUM_VARS-1:0] assigned;
  logic [NUM_VARS-1:0] neg;

  logic                grant_valid;
  logic [PTR_W-1:0]    grant_idx;
  logic [PTR_W-1:0]    cand;
  logic                do_capture, push_en, tbl_we, set_err, set_conf;
  logic                lit_sign, lit_bad;
  logic [LIT_W-1:0]    mag;
  logic [IDX_W-1:0]    var_idx;

  // Round-robin search for the first non-empty UCQ_in starting at rr_ptr.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_PE; k++) begin
      cand = PTR_W'((int'(rr_ptr) + k) % NUM_PE);
      if (!grant_valid && !UCQ_in_empty[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // The most negative literal negates to itself and so lands above NUM_VARS.
  assign lit_sign = lit_reg[LIT_W-1];
  assign mag      = lit_sign ? (~lit_reg + LIT_W'(1)) : lit_reg;
  assign lit_bad  = (mag == '0) || (mag > LIT_W'(NUM_VARS));
  assign var_idx  = IDX_W'(mag - LIT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    do_capture = 1'b0;
    push_en    = 1'b0;
    tbl_we     = 1'b0;
    set_err    = 1'b0;
    set_conf   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!conflict && grant_valid) begin
          do_capture = 1'b1;
          state_next = S_CHECK;
        end
      end
      S_CHECK: begin
        if (lit_bad) begin
          set_err    = 1'b1;
          state_next = S_IDLE;
        end else if (!assigned[var_idx]) begin
          tbl_we     = 1'b1;
          state_next = S_BCAST;
        end else if (neg[var_idx] == lit_sign) begin
          state_next = S_IDLE;
        end else begin
          set_conf   = 1'b1;
          state_next = S_HALT;
        end
      end
      S_BCAST: begin
        if (!(|UCQ_out_full)) begin
          push_en    = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_HALT:  state_next = S_HALT;
      default: state_next = S_IDLE;
    endcase
    // Clear wins over everything decided above, including a grant or a broadcast.
    if (clear) begin
      state_next = S_IDLE;
      do_capture = 1'b0;
      push_en    = 1'b0;
      tbl_we     = 1'b0;
      set_err    = 1'b0;
      set_conf   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= '0;
      lit_reg  <= '0;
      assigned <= '0;
      neg      <= '0;
      conflict <= 1'b0;
      lit_err  <= 1'b0;
    end else if (clear) begin
      rr_ptr   <= '0;
      assigned <= '0;
      neg      <= '0;
      conflict <= 1'b0;
      lit_err  <= 1'b0;
    end else begin
      if (do_capture) begin
        lit_reg <= UCQ_in2uarb_uc[grant_idx*LIT_W +: LIT_W];
        rr_ptr  <= (grant_idx == PTR_W'(NUM_PE - 1)) ? '0 : grant_idx + PTR_W'(1);
      end
      if (tbl_we) begin
        assigned[var_idx] <= 1'b1;
        neg[var_idx]      <= lit_sign;
      end
      if (set_err)  lit_err  <= 1'b1;
      if (set_conf) conflict <= 1'b1;
    end
  end

  assign ucarb2UCQ_in_pop   = (do_capture && !rst) ? (NUM_PE'(1) << grant_idx) : '0;
  assign ucarb2UCQ_out_push = {NUM_PE{push_en && !rst}};
  assign ucarb2UCQ_out_uc   = push_en ? lit_reg : '0;
  assign quiescent          = !rst && (state == S_IDLE) && (&UCQ_in_empty) &&
                              (&proc_stall) && !conflict;

endmodule

// File: tb/tb_uc_arbiter.sv
// Bench for uc_arbiter: directed scenarios followed by random traffic, every cycle
// compared against a transaction-level model of queues, table and broadcast timing.
module tb_uc_arbiter;

  localparam int INF = 32'h7fff_ffff;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic [3:0]  UCQ_in_empty;
  logic [63:0] UCQ_in2uarb_uc;
  logic [3:0]  ucarb2UCQ_in_pop;
  logic [3:0]  UCQ_out_full;
  logic [3:0]  ucarb2UCQ_out_push;
  logic [15:0] ucarb2UCQ_out_uc;
  logic [3:0]  proc_stall;
  logic        conflict;
  logic        lit_err;
  logic        quiescent;

  uc_arbiter #(.NUM_PE(4), .LIT_W(16), .NUM_VARS(256)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .UCQ_in_empty(UCQ_in_empty), .UCQ_in2uarb_uc(UCQ_in2uarb_uc),
    .ucarb2UCQ_in_pop(ucarb2UCQ_in_pop), .UCQ_out_full(UCQ_out_full),
    .ucarb2UCQ_out_push(ucarb2UCQ_out_push), .ucarb2UCQ_out_uc(ucarb2UCQ_out_uc),
    .proc_stall(proc_stall), .conflict(conflict), .lit_err(lit_err),
    .quiescent(quiescent)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Stimulus knobs and the model of the four UCQ_in FIFOs.
  logic [15:0] in_q[4][$];
  logic [3:0]  full_v, stall_v;
  logic        clr_v;

  // Reference model: assignment table as +1/-1/0 per variable, plus timing bookkeeping.
  int          tbl[257];
  int          rr, cyc, free_at, push_at, conf_at, err_at;
  bit          halted, pending;
  logic [15:0] pend_lit;

  logic [3:0]  last_pop, last_push;
  logic [15:0] last_uc;
  logic        last_q;
  int          pop_cnt, push_cnt;
  int          pop_log[$];

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear(input int free_cycle);
    for (int v = 0; v <= 256; v++) tbl[v] = 0;
    rr      = 0;
    halted  = 1'b0;
    pending = 1'b0;
    free_at = free_cycle;
    push_at = INF;
    conf_at = INF;
    err_at  = INF;
  endtask

  task automatic enqueue(input int p, input int lit);
    in_q[p].push_back(16'(lit));
  endtask

  function automatic int log_at(input int i);
    return (pop_log.size() > i) ? pop_log[i] : -1;
  endfunction

  function automatic int rand_lit();
    int r, v;
    r = int'($urandom_range(0, 19));
    if (r == 0) return 0;
    if (r == 1) return 300;
    v = int'($urandom_range(1, 16));
    return ($urandom_range(0, 1) == 1) ? -v : v;
  endfunction

  // One clock cycle: drive, predict, compare, advance model, step to next negedge.
  task automatic apply_stimulus();
    logic [3:0] exp_pop, exp_push;
    logic       exp_q, exp_conf, exp_err;
    bit         all_empty;
    int         g, idx, li, v;
    all_empty = 1'b1;
    for (int i = 0; i < 4; i++) begin
      UCQ_in_empty[i] = (in_q[i].size() == 0);
      UCQ_in2uarb_uc[i*16 +: 16] = (in_q[i].size() == 0) ? 16'hdead : in_q[i][0];
      if (in_q[i].size() != 0) all_empty = 1'b0;
    end
    UCQ_out_full = full_v;
    proc_stall   = stall_v;
    clear        = clr_v;
    #1;
    g = -1;
    if (!clr_v && !halted && cyc >= free_at) begin
      for (int k = 0; k < 4; k++) begin
        idx = (rr + k) % 4;
        if (g < 0 && in_q[idx].size() != 0) g = idx;
      end
    end
    exp_pop  = (g >= 0) ? (4'b0001 << g) : 4'b0000;
    exp_push = (!clr_v && pending && cyc >= push_at && full_v == 4'b0000) ? 4'hf : 4'h0;
    exp_conf = (cyc >= conf_at);
    exp_err  = (cyc >= err_at);
    exp_q    = !halted && !pending && (cyc >= free_at) && all_empty &&
               (stall_v == 4'hf) && !exp_conf;
    check_output("pop", ucarb2UCQ_in_pop, exp_pop);
    check_output("push", ucarb2UCQ_out_push, exp_push);
    if (exp_push != 4'h0) check_output("uc", ucarb2UCQ_out_uc, pend_lit);
    check_output("conflict", conflict, exp_conf);
    check_output("lit_err", lit_err, exp_err);
    check_output("quiescent", quiescent, exp_q);
    last_pop  = ucarb2UCQ_in_pop;
    last_push = ucarb2UCQ_out_push;
    last_uc   = ucarb2UCQ_out_uc;
    last_q    = quiescent;
    if (ucarb2UCQ_in_pop != 4'h0) pop_cnt++;
    if (ucarb2UCQ_out_push != 4'h0) push_cnt++;
    for (int i = 0; i < 4; i++) if (ucarb2UCQ_in_pop[i]) pop_log.push_back(i);
    if (clr_v) begin
      model_clear(cyc + 1);
    end else begin
      if (exp_push != 4'h0) begin
        pending = 1'b0;
        free_at = cyc + 1;
      end
      if (g >= 0) begin
        pend_lit = in_q[g].pop_front();
        rr = (g + 1) % 4;
        li = int'($signed(pend_lit));
        v  = (li < 0) ? -li : li;
        if (v == 0 || v > 256) begin
          if (err_at == INF) err_at = cyc + 2;
          free_at = cyc + 2;
        end else if (tbl[v] == 0) begin
          tbl[v]  = (li < 0) ? -1 : 1;
          pending = 1'b1;
          push_at = cyc + 2;
          free_at = INF;
        end else if ((tbl[v] < 0) == (li < 0)) begin
          free_at = cyc + 2;
        end else begin
          halted  = 1'b1;
          conf_at = cyc + 2;
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) apply_stimulus();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int pc, pu;
    rst = 1'b1;
    clear = 1'b0;
    full_v = 4'h0;
    stall_v = 4'hf;
    clr_v = 1'b0;
    cyc = 0;
    pop_cnt = 0;
    push_cnt = 0;
    model_clear(0);
    UCQ_out_full = 4'h0;
    proc_stall = 4'hf;
    UCQ_in_empty = 4'b1110;
    UCQ_in2uarb_uc = 64'h0003;
    repeat (2) @(negedge clk);
    #1;
    check_output("rst_pop", ucarb2UCQ_in_pop, 4'h0);
    check_output("rst_push", ucarb2UCQ_out_push, 4'h0);
    check_output("rst_conflict", conflict, 1'b0);
    check_output("rst_lit_err", lit_err, 1'b0);
    check_output("rst_quiescent", quiescent, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    apply_stimulus();
    check_output("idle_quiescent", last_q, 1'b1);

    // Basic broadcast from PE1: pop now, push two cycles later.
    enqueue(1, 5);
    apply_stimulus();
    check_output("t2_pop", last_pop, 4'b0010);
    apply_stimulus();
    check_output("t2_check_nopush", last_push, 4'h0);
    apply_stimulus();
    check_output("t2_push", last_push, 4'hf);
    check_output("t2_uc", last_uc, 16'd5);

    // Duplicate is dropped, opposite polarity halts, clear recovers.
    pu = push_cnt;
    enqueue(0, 5);
    run(5);
    check_output("t4_dup_nopush", push_cnt, pu);
    enqueue(2, -5);
    run(4);
    check_output("t4_conflict", conflict, 1'b1);
    pc = pop_cnt;
    enqueue(3, 7);
    run(6);
    check_output("t4_halt_nopop", pop_cnt, pc);
    clr_v = 1'b1;
    apply_stimulus();
    clr_v = 1'b0;
    apply_stimulus();
    check_output("t4_clear_conflict", conflict, 1'b0);
    pu = push_cnt;
    enqueue(0, 5);
    run(10);
    check_output("t4_table_cleared", push_cnt, pu + 2);

    // Round robin from rr_ptr=1 with PE0, PE2, PE3 pending.
    pop_log.delete();
    enqueue(0, 2);
    enqueue(2, 3);
    enqueue(3, 4);
    run(12);
    check_output("t3_grant0", log_at(0), 2);
    check_output("t3_grant1", log_at(1), 3);
    check_output("t3_grant2", log_at(2), 0);
    pop_log.delete();
    enqueue(0, 6);
    enqueue(1, 8);
    run(8);
    check_output("t3_rr_after", log_at(0), 1);

    // Backpressure on one UCQ_out holds the broadcast and blocks further pops.
    full_v = 4'b1000;
    enqueue(0, 9);
    run(2);
    enqueue(1, 10);
    for (int i = 0; i < 10; i++) begin
      apply_stimulus();
      check_output("t5_hold_push", last_push, 4'h0);
      check_output("t5_hold_pop", last_pop, 4'h0);
    end
    full_v = 4'h0;
    apply_stimulus();
    check_output("t5_release_push", last_push, 4'hf);
    check_output("t5_release_uc", last_uc, 16'd9);
    run(6);

    // Out-of-range literals are popped and dropped with lit_err.
    pu = push_cnt;
    pc = pop_cnt;
    enqueue(0, 0);
    enqueue(1, 300);
    enqueue(2, -32768);
    run(12);
    check_output("t6_lit_err", lit_err, 1'b1);
    check_output("t6_nopush", push_cnt, pu);
    check_output("t6_popped", pop_cnt, pc + 3);
    clr_v = 1'b1;
    apply_stimulus();
    clr_v = 1'b0;
    apply_stimulus();
    check_output("t6_clear_lit_err", lit_err, 1'b0);

    // Asynchronous reset in the middle of a stalled broadcast.
    full_v = 4'hf;
    enqueue(2, 11);
    run(4);
    #2 rst = 1'b1;
    #1;
    check_output("t1_push", ucarb2UCQ_out_push, 4'h0);
    check_output("t1_conflict", conflict, 1'b0);
    check_output("t1_pop", ucarb2UCQ_in_pop, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    full_v = 4'h0;
    model_clear(0);
    apply_stimulus();
    check_output("t1_quiescent", last_q, 1'b1);

    // Random traffic with backpressure, stalls, conflicts and clears.
    for (int n = 0; n < 1500; n++) begin
      int p;
      if ($urandom_range(0, 2) == 0) begin
        p = int'($urandom_range(0, 3));
        if (in_q[p].size() < 4) enqueue(p, rand_lit());
      end
      for (int i = 0; i < 4; i++) begin
        full_v[i]  = ($urandom_range(0, 4) == 0);
        stall_v[i] = ($urandom_range(0, 4) != 0);
      end
      clr_v = (halted && $urandom_range(0, 3) == 0) || ($urandom_range(0, 299) == 0);
      apply_stimulus();
    end
    full_v = 4'h0;
    stall_v = 4'hf;
    clr_v = 1'b0;
    run(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
